dmem_responder: RTL

- Responder end of the memory-stage load/store interface; the pipeline's memory stage is the initiator.
- Accepts one request at a time over a valid/ready handshake.
- Services each request after a programmable number of wait states. Byte, halfword and word stores are merged into a word-organised array. Load data is returned sign- or zero-extended per funct3.
- Drives a stall flag so the pipeline holds its memory stage while a request is outstanding.

---
 rtl/dmem_responder.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - load/store memory responder with programmable wait states
// Optional misaligned-access trap: define DMEM_MISALIGN_TRAP_EN.
module dmem_responder #(
    parameter int DEPTH       = 256,
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        stall
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                we_q;
    logic [2:0]          f3_q;
    logic [ADDR_W+1:0]   addr_q;
    logic [31:0]         wdata_q;
    logic [31:0]         rdata_q;
    logic                err_q;
    logic [31:0]         mem_q [DEPTH];

    logic                accept;
    logic                illegal;
    logic                misalign;
    logic                bad;
    logic [1:0]          lo;
    logic [31:0]         word;
    logic [31:0]         shifted;
    logic [7:0]          byte_sel;
    logic [15:0]         half_sel;
    logic [31:0]         load_data;
    logic [31:0]         resp_data;
    logic [3:0]          be;
    logic [31:0]         wpat;
    logic                mem_we;
    logic                unused_addr_bits;

    assign unused_addr_bits = ^req_addr[31:ADDR_W+2];
    assign accept = req_valid && (state_q == S_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= req_we;
                f3_q    <= req_funct3;
                addr_q  <= req_addr[ADDR_W+1:0];
                wdata_q <= req_wdata;
            end
            if (state_q == S_RESP) begin
                rdata_q <= resp_data;
                err_q   <= bad;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: if (accept) begin
                cnt_d   = 4'(WAIT_CYCLES);
                state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Decode of the captured request; only meaningful while in RESP.
    always_comb begin
        illegal = (f3_q == 3'b011) || (f3_q == 3'b110) || (f3_q == 3'b111);
`ifdef DMEM_MISALIGN_TRAP_EN
        misalign = ((f3_q[1:0] == 2'b01) && addr_q[0]) ||
                   ((f3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
        lo       = addr_q[1:0];
`else
        misalign = 1'b0;
        case (f3_q[1:0])
            2'b01:   lo = {addr_q[1], 1'b0};
            2'b10:   lo = 2'b00;
            default: lo = addr_q[1:0];
        endcase
`endif
        bad      = illegal || misalign;
        word     = mem_q[addr_q[ADDR_W+1:2]];
        shifted  = word >> {lo, 3'b000};
        byte_sel = shifted[7:0];
        half_sel = lo[1] ? word[31:16] : word[15:0];
        case (f3_q)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_data = {24'd0, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_data = {16'd0, half_sel};
            3'b010:  load_data = word;
            default: load_data = 32'd0;
        endcase
        resp_data = (we_q || bad) ? 32'd0 : load_data;
        case (f3_q[1:0])
            2'b00:   begin be = 4'b0001 << lo; wpat = {4{wdata_q[7:0]}}; end
            2'b01:   begin be = lo[1] ? 4'b1100 : 4'b0011; wpat = {2{wdata_q[15:0]}}; end
            2'b10:   begin be = 4'b1111; wpat = wdata_q; end
            default: begin be = 4'b0000; wpat = 32'd0; end
        endcase
        mem_we = (state_q == S_RESP) && we_q && !bad;
    end

    // Array is deliberately not reset; stores land on the edge leaving RESP.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem_q[addr_q[ADDR_W+1:2]][8*i +: 8] <= wpat[8*i +: 8];
            end
        end
    end

    assign req_ready  = (state_q == S_IDLE) && rst;
    assign stall      = (state_q != S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = resp_valid ? resp_data : rdata_q;
    assign resp_err   = resp_valid ? bad : err_q;
endmodule
